taskb_sequencer: RTL and testbench

Control FSM for Task B; sits directly upstream of the 3-second timer and consumes its completion flag.
- Takes start/abort pushbuttons and drives is_taskB_running into the timer.
- Reads is_3s back and sequences ROUNDS consecutive 3-s rounds, with a one-cycle gap between rounds so the timer clears.
- Drives a 16-LED progress display and a completion pulse for the top level.

---
 rtl/taskb_pkg.sv | 26 ++
 rtl/btn_conditioner.sv | 73 +++++++
 rtl/taskb_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_taskb_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taskb_pkg.sv
// Shared types and constants for the Task B sequencer.
package taskb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int                LED_W      = 16;
  localparam logic [LED_W-1:0]  LED_ALL_ON = 16'hFFFF;

  // Counter width for a count range of n values; a range of 1 still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot LED pattern for a chase position.
  function automatic logic [LED_W-1:0] led_onehot(input logic [3:0] pos);
    logic [LED_W-1:0] one;
    one = {{(LED_W-1){1'b0}}, 1'b1};
    return one << pos;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, optional stable-level
// debounce filter, and a rising-edge strobe on the conditioned level.
// Build option: define TASKB_DEBOUNCE_EN to include the DEBOUNCE_CYCLES filter;
// without it the synchronised level is used directly (clean inputs, fast sim).
module btn_conditioner
  import taskb_pkg::*;
`ifdef TASKB_DEBOUNCE_EN
  #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
  )
`endif
  (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic evt
  );

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef TASKB_DEBOUNCE_EN
  localparam int             DW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt;
  logic          db_level;

  // Accept a level change only after it has been seen on DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_level <= sync2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync2;
`endif

  // Remember the previous conditioned level for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign evt = level & ~level_d;

endmodule

// File: rtl/taskb_sequencer.sv
// Task B control FSM: drives the 3-s timer enable, counts ROUNDS timer
// completions with a one-cycle gap between them, shows a chase on the LEDs,
// and strobes done_pulse when the run completes.
// Build option: TASKB_DEBOUNCE_EN enables the button debounce filters.
module taskb_sequencer
  import taskb_pkg::*;
  #(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int CHASE_CYCLES     = 10_000_000,
    parameter int ROUNDS           = 3,
    parameter int DONE_HOLD_CYCLES = 50_000_000
  )
  (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_start,
    input  logic             btn_abort,
    input  logic             is_3s,
    output logic             is_taskB_running,
    output logic [LED_W-1:0] led,
    output logic [3:0]       round_idx,
    output logic             done_pulse
  );

  if (ROUNDS < 1 || ROUNDS > 15 || DEBOUNCE_CYCLES < 1 ||
      CHASE_CYCLES < 1 || DONE_HOLD_CYCLES < 1) begin : g_bad_params
    $error("taskb_sequencer: parameter out of range");
  end

  localparam int             CW         = cnt_width(CHASE_CYCLES);
  localparam int             HW         = cnt_width(DONE_HOLD_CYCLES);
  localparam logic [CW-1:0]  CHASE_LAST = CW'(CHASE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(DONE_HOLD_CYCLES - 1);
  localparam logic [3:0]     ROUND_LAST = 4'(ROUNDS - 1);

  logic start_evt;
  logic abort_evt;

`ifdef TASKB_DEBOUNCE_EN
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_cond (
    .clock (clock),
    .reset (reset),
    .btn   (btn_start),
    .evt   (start_evt)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abort_cond (
    .clock (clock),
    .reset (reset),
    .btn   (btn_abort),
    .evt   (abort_evt)
  );
`else
  btn_conditioner u_start_cond (
    .clock (clock),
    .reset (reset),
    .btn   (btn_start),
    .evt   (start_evt)
  );

  btn_conditioner u_abort_cond (
    .clock (clock),
    .reset (reset),
    .btn   (btn_abort),
    .evt   (abort_evt)
  );
`endif

  state_t           state;
  state_t           state_next;
  logic [3:0]       chase_pos;
  logic [3:0]       pos_next;
  logic [CW-1:0]    chase_cnt;
  logic [CW-1:0]    ccnt_next;
  logic [HW-1:0]    hold_cnt;
  logic [HW-1:0]    hcnt_next;
  logic             running_next;
  logic [LED_W-1:0] led_next;
  logic [3:0]       round_next;
  logic             pulse_next;

  // Next-state and next-output logic; abort is checked first so it beats start and is_3s.
  always_comb begin
    state_next   = state;
    pos_next     = chase_pos;
    ccnt_next    = chase_cnt;
    hcnt_next    = hold_cnt;
    running_next = 1'b0;
    led_next     = led;
    round_next   = round_idx;
    pulse_next   = 1'b0;

    case (state)
      IDLE: begin
        led_next   = '0;
        round_next = 4'd0;
        if (start_evt && !abort_evt) begin
          state_next   = RUN;
          pos_next     = 4'd0;
          ccnt_next    = '0;
          running_next = 1'b1;
          led_next     = led_onehot(4'd0);
        end
      end

      RUN: begin
        if (abort_evt) begin
          state_next = IDLE;
          pos_next   = 4'd0;
          ccnt_next  = '0;
          led_next   = '0;
          round_next = 4'd0;
        end else if (is_3s) begin
          state_next = GAP;
          ccnt_next  = '0;
        end else begin
          running_next = 1'b1;
          if (chase_cnt == CHASE_LAST) begin
            ccnt_next = '0;
            pos_next  = chase_pos + 4'd1;
          end else begin
            ccnt_next = chase_cnt + 1'b1;
          end
          led_next = led_onehot(pos_next);
        end
      end

      GAP: begin
        if (abort_evt) begin
          state_next = IDLE;
          pos_next   = 4'd0;
          led_next   = '0;
          round_next = 4'd0;
        end else if (round_idx == ROUND_LAST) begin
          state_next = DONE;
          hcnt_next  = '0;
          led_next   = LED_ALL_ON;
          pulse_next = 1'b1;
        end else begin
          state_next   = RUN;
          round_next   = round_idx + 4'd1;
          pos_next     = 4'd0;
          ccnt_next    = '0;
          running_next = 1'b1;
          led_next     = led_onehot(4'd0);
        end
      end

      DONE: begin
        if (abort_evt || hold_cnt == HOLD_LAST) begin
          state_next = IDLE;
          hcnt_next  = '0;
          pos_next   = 4'd0;
          led_next   = '0;
          round_next = 4'd0;
        end else begin
          hcnt_next = hold_cnt + 1'b1;
          led_next  = LED_ALL_ON;
        end
      end

      default: begin
        state_next = IDLE;
        pos_next   = 4'd0;
        ccnt_next  = '0;
        hcnt_next  = '0;
        led_next   = '0;
        round_next = 4'd0;
      end
    endcase
  end

  // State, counters and all outputs are registered together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      chase_pos        <= 4'd0;
      chase_cnt        <= '0;
      hold_cnt         <= '0;
      is_taskB_running <= 1'b0;
      led              <= '0;
      round_idx        <= 4'd0;
      done_pulse       <= 1'b0;
    end else begin
      state            <= state_next;
      chase_pos        <= pos_next;
      chase_cnt        <= ccnt_next;
      hold_cnt         <= hcnt_next;
      is_taskB_running <= running_next;
      led              <= led_next;
      round_idx        <= round_next;
      done_pulse       <= pulse_next;
    end
  end

endmodule

// File: tb/tb_taskb_sequencer.sv
// Testbench for taskb_sequencer with a 3-s timer stub, a behavioural model
// and a scoreboard compared by an independent monitor every cycle.
// Build option: TASKB_DEBOUNCE_EN must match the RTL build.
module tb_taskb_sequencer;

  localparam int DEB  = 4;
  localparam int CH   = 3;
  localparam int RND  = 2;
  localparam int HOLD = 5;
`ifdef TASKB_DEBOUNCE_EN
  localparam int EVT_LAT = 2 + DEB;
`else
  localparam int EVT_LAT = 2;
`endif

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_GAP  = 2;
  localparam int P_DONE = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        btn_start;
  logic        btn_abort;
  logic        is_3s;
  logic        is_taskB_running;
  logic [15:0] led;
  logic [3:0]  round_idx;
  logic        done_pulse;

  typedef struct packed {
    logic        running;
    logic [15:0] led;
    logic [3:0]  rnd;
    logic        pulse;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  int m_phase = P_IDLE;
  int m_round = 0;
  int m_rc = 0;
  int m_dc = 0;
  int m_runhi = 0;
  bit m_pulse = 1'b0;
  int edge_n = 0;
  int start_due = -1;
  int abort_due = -1;
  int start_rel = -1;
  int abort_rel = -1;
  int release_edge = -1;
  bit hold_low = 1'b0;
  bit force_hi = 1'b0;

  always #5 clock = ~clock;

  taskb_sequencer #(
    .DEBOUNCE_CYCLES  (DEB),
    .CHASE_CYCLES     (CH),
    .ROUNDS           (RND),
    .DONE_HOLD_CYCLES (HOLD)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .btn_start        (btn_start),
    .btn_abort        (btn_abort),
    .is_3s            (is_3s),
    .is_taskB_running (is_taskB_running),
    .led              (led),
    .round_idx        (round_idx),
    .done_pulse       (done_pulse)
  );

  function automatic logic [15:0] chase_led(input int rc);
    logic [15:0] v;
    v = 16'h0001;
    return v << ((rc / CH) % 16);
  endfunction

  function automatic exp_t model_out();
    exp_t o;
    o.running = (m_phase == P_RUN);
    if (m_phase == P_IDLE)      o.led = 16'h0000;
    else if (m_phase == P_DONE) o.led = 16'hFFFF;
    else                        o.led = chase_led(m_rc);
    o.rnd   = 4'(m_round);
    o.pulse = m_pulse;
    return o;
  endfunction

  task automatic model_idle();
    m_phase = P_IDLE;
    m_round = 0;
    m_rc    = 0;
    m_dc    = 0;
  endtask

  // Advance the reference model by the clock edge that just happened.
  task automatic model_step();
    bit s_evt;
    bit a_evt;
    s_evt   = (start_due == edge_n);
    a_evt   = (abort_due == edge_n);
    m_pulse = 1'b0;
    if (reset) begin
      model_idle();
    end else begin
      case (m_phase)
        P_IDLE: if (s_evt && !a_evt) begin m_phase = P_RUN; m_round = 0; m_rc = 0; end
        P_RUN: begin
          if (a_evt)      model_idle();
          else if (is_3s) m_phase = P_GAP;
          else            m_rc++;
        end
        P_GAP: begin
          if (a_evt) model_idle();
          else if (m_round == RND - 1) begin m_phase = P_DONE; m_dc = 1; m_pulse = 1'b1; end
          else begin m_phase = P_RUN; m_round++; m_rc = 0; end
        end
        default: begin
          if (a_evt || m_dc == HOLD) model_idle();
          else m_dc++;
        end
      endcase
    end
  endtask

  // One clock: step the model, queue the expectation, update the timer stub and buttons.
  task automatic apply_stimulus();
    @(posedge clock);
    edge_n++;
    #1;
    model_step();
    sb_q.push_back(model_out());
    if (m_phase == P_RUN) m_runhi++;
    else                  m_runhi = 0;
    if (release_edge >= 0 && edge_n >= release_edge) begin
      hold_low     = 1'b0;
      release_edge = -1;
    end
    is_3s = force_hi || (!hold_low && m_runhi >= 20);
    if (edge_n == start_rel) btn_start = 1'b0;
    if (edge_n == abort_rel) btn_abort = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) apply_stimulus();
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    start_due = edge_n + 1 + EVT_LAT;
    start_rel = edge_n + 8;
  endtask

  task automatic press_abort();
    btn_abort = 1'b1;
    abort_due = edge_n + 1 + EVT_LAT;
    abort_rel = edge_n + 8;
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int k;
    k = 0;
    while (m_phase != ph && k < budget) begin
      apply_stimulus();
      k++;
    end
    checks++;
    if (m_phase != ph) begin
      errors++;
      $display("[TB] FAIL wait_phase: phase=%0d required=%0d within %0d cycles", m_phase, ph, budget);
    end
  endtask

  task automatic wait_round1(input int budget);
    int k;
    k = 0;
    while (!(m_phase == P_RUN && m_round == 1) && k < budget) begin
      apply_stimulus();
      k++;
    end
    checks++;
    if (!(m_phase == P_RUN && m_round == 1)) begin
      errors++;
      $display("[TB] FAIL wait_round1: round=%0d required=1 within %0d cycles", m_round, budget);
    end
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if ({is_taskB_running, led, round_idx, done_pulse} !== e) begin
      errors++;
      $display("[TB] FAIL outputs t=%0t: running=%0b led=%h round=%0d pulse=%0b, required running=%0b led=%h round=%0d pulse=%0b",
               $time, is_taskB_running, led, round_idx, done_pulse, e.running, e.led, e.rnd, e.pulse);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare away from the active edge.
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_output(mon_e);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    btn_start = 1'b0;
    btn_abort = 1'b0;
    is_3s     = 1'b0;
    run_cycles(3);
    reset = 1'b0;
    run_cycles(3);

    $display("[TB] start and complete");
    press_start();
    wait_phase(P_RUN, 20);
    wait_phase(P_DONE, 200);
    wait_phase(P_IDLE, 20);
    run_cycles(25);

    $display("[TB] is_3s ignored in IDLE");
    force_hi = 1'b1;
    run_cycles(5);
    force_hi = 1'b0;
    run_cycles(3);

    $display("[TB] chase wrap");
    hold_low = 1'b1;
    press_start();
    wait_phase(P_RUN, 20);
    run_cycles(60);
    hold_low = 1'b0;
    wait_phase(P_IDLE, 300);
    run_cycles(25);

    $display("[TB] abort in round 1");
    for (int it = 0; it < 3; it++) begin
      press_start();
      wait_round1(100);
      run_cycles($urandom_range(0, 10));
      press_abort();
      wait_phase(P_IDLE, 40);
      run_cycles(25);
    end

    $display("[TB] abort at random points");
    for (int it = 0; it < 6; it++) begin
      press_start();
      wait_phase(P_RUN, 20);
      run_cycles($urandom_range(0, 80));
      press_abort();
      wait_phase(P_IDLE, 200);
      run_cycles(25);
    end

    $display("[TB] start and abort together in IDLE");
    press_start();
    press_abort();
    run_cycles(25);

    $display("[TB] abort together with is_3s");
    hold_low = 1'b1;
    press_start();
    wait_phase(P_RUN, 20);
    run_cycles(30);
    press_abort();
    release_edge = edge_n + EVT_LAT;
    wait_phase(P_IDLE, 40);
    run_cycles(25);

`ifdef TASKB_DEBOUNCE_EN
    $display("[TB] bouncing start button");
    for (int i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      run_cycles(2);
    end
    btn_start = 1'b0;
    run_cycles(20);
`endif

    $display("[TB] reset during DONE");
    press_start();
    wait_phase(P_DONE, 200);
    reset = 1'b1;
    apply_stimulus();
    reset = 1'b0;
    run_cycles(25);
    press_start();
    wait_phase(P_RUN, 20);
    wait_phase(P_DONE, 200);
    wait_phase(P_IDLE, 20);
    run_cycles(3);

    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
